axi_stream_packet_rx: RTL and testbench

Parametrised AXI4-Stream packet receiver: accepts packets on a slave stream port and stores each one whole in one of two ping-pong buffer banks. It then presents the packet to a local consumer through a random-access read port. Packets longer than the bank depth are accepted in full, truncated to the bank depth, and flagged. It sits at the sink end of a stream path, ahead of packet-processing logic that needs whole packets, and replaces the fixed 8-deep single-buffer slave.

---
 rtl/axi_stream_pkg.sv | 18 +
 rtl/axi_stream_if.sv | 14 +
 rtl/axi_stream_bank_ram.sv | 35 +++
 rtl/axi_stream_packet_rx.sv | 139 +++++++++++++
 tb/tb_axi_stream_packet_rx.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_stream_pkg.sv
// rtl/axi_stream_pkg.sv - shared types and constants for the stream packet receiver
package axi_stream_pkg;

  typedef logic [31:0] data_t;

  typedef enum logic [1:0] {
    WAIT    = 2'd0,
    RECV    = 2'd1,
    DISCARD = 2'd2
  } rx_state_t;

  localparam int DROP_CNT_W = 16;

  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/axi_stream_if.sv
// rtl/axi_stream_if.sv - AXI4-Stream handshake bundle with master/slave views
interface axi_stream_if #(
  parameter int DATA_W = 32
);

  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic              tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);

endinterface

// File: rtl/axi_stream_bank_ram.sv
// rtl/axi_stream_bank_ram.sv - two-bank packet storage, one write port, one registered read port
module axi_stream_bank_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              aclk,
  input  logic              areset_n,
  input  logic              we,
  input  logic              wr_bank,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_bank,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  // Storage is left unreset so it maps onto plain RAM; only the output register clears.
  logic [DATA_W-1:0] mem [2*DEPTH];

  always_ff @(posedge aclk) begin
    if (we) begin
      mem[{wr_bank, wr_addr}] <= wr_data;
    end
  end

  always_ff @(posedge aclk) begin
    if (!areset_n) begin
      rd_data <= '0;
    end else begin
      rd_data <= mem[{rd_bank, rd_addr}];
    end
  end

endmodule

// File: rtl/axi_stream_packet_rx.sv
// rtl/axi_stream_packet_rx.sv - ping-pong packet receiver presenting whole packets on a read port
module axi_stream_packet_rx
  import axi_stream_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic                  aclk,
  input  logic                  areset_n,
  axi_stream_if.slave           s_axi_stream,
  output logic                  pkt_valid,
  output logic [LW-1:0]         pkt_len,
  output logic                  pkt_err,
  input  logic [AW-1:0]         rd_addr,
  output logic [DATA_W-1:0]     rd_data,
  input  logic                  pkt_ack,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  localparam logic [1:0] ST_WAIT    = WAIT;
  localparam logic [1:0] ST_RECV    = RECV;
  localparam logic [1:0] ST_DISCARD = DISCARD;

  logic [1:0]    state, state_nxt;
  logic [AW-1:0] cnt, cnt_nxt;
  logic          wr_bank, rd_bank;
  logic [1:0]    bank_full;
  logic [LW-1:0] len_r [2];
  logic          err_r [2];

  logic          hs;
  logic          ram_we;
  logic          commit;
  logic [LW-1:0] commit_len;
  logic          commit_err;
  logic          ack_take;

  // tready depends only on registered state, never on tvalid or pkt_ack.
  assign s_axi_stream.tready = (state == ST_RECV) || (state == ST_DISCARD);
  assign hs       = s_axi_stream.tvalid && s_axi_stream.tready;
  assign ack_take = pkt_ack && bank_full[rd_bank];

  assign pkt_valid = bank_full[rd_bank];
  assign pkt_len   = len_r[rd_bank];
  assign pkt_err   = err_r[rd_bank];

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    ram_we     = 1'b0;
    commit     = 1'b0;
    commit_len = '0;
    commit_err = 1'b0;
    case (state)
      ST_WAIT: begin
        if (!bank_full[wr_bank]) begin
          state_nxt = ST_RECV;
        end
      end
      ST_RECV: begin
        if (hs) begin
          ram_we = 1'b1;
          if (s_axi_stream.tlast) begin
            commit     = 1'b1;
            commit_len = {1'b0, cnt} + LW'(1);
            cnt_nxt    = '0;
          end else if (cnt == AW'(DEPTH - 1)) begin
            state_nxt = ST_DISCARD;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      ST_DISCARD: begin
        if (hs && s_axi_stream.tlast) begin
          commit     = 1'b1;
          commit_len = LW'(DEPTH);
          commit_err = 1'b1;
        end
      end
      default: state_nxt = ST_WAIT;
    endcase
    // After a commit the writer flips banks, so it can only keep receiving if the other bank is free.
    if (commit) begin
      state_nxt = bank_full[~wr_bank] ? ST_WAIT : ST_RECV;
    end
  end

  always_ff @(posedge aclk) begin
    if (!areset_n) begin
      state     <= ST_WAIT;
      cnt       <= '0;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      bank_full <= 2'b00;
      len_r[0]  <= '0;
      len_r[1]  <= '0;
      err_r[0]  <= 1'b0;
      err_r[1]  <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      // A commit and an ack always address different banks, so both updates can land together.
      if (commit) begin
        bank_full[wr_bank] <= 1'b1;
        len_r[wr_bank]     <= commit_len;
        err_r[wr_bank]     <= commit_err;
        wr_bank            <= ~wr_bank;
        if (commit_err) begin
          drop_cnt <= sat_inc(drop_cnt);
        end
      end
      if (ack_take) begin
        bank_full[rd_bank] <= 1'b0;
        rd_bank            <= ~rd_bank;
      end
    end
  end

  axi_stream_bank_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_bank_ram (
    .aclk     (aclk),
    .areset_n (areset_n),
    .we       (ram_we),
    .wr_bank  (wr_bank),
    .wr_addr  (cnt),
    .wr_data  (s_axi_stream.tdata),
    .rd_bank  (rd_bank),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data)
  );

endmodule

// File: tb/tb_axi_stream_packet_rx.sv
// tb/tb_axi_stream_packet_rx.sv - scoreboard bench for the ping-pong packet receiver
module tb_axi_stream_packet_rx;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 8;

  logic        aclk = 1'b0;
  logic        areset_n = 1'b0;
  logic        pkt_valid;
  logic [3:0]  pkt_len;
  logic        pkt_err;
  logic [2:0]  rd_addr = '0;
  logic [31:0] rd_data;
  logic        pkt_ack = 1'b0;
  logic [15:0] drop_cnt;

  int checks   = 0;
  int failures = 0;
  int exp_drop = 0;

  logic [31:0] exp_data_q[$];
  int          exp_len_q[$];
  logic        exp_err_q[$];

  always #5 aclk = ~aclk;

  axi_stream_if #(.DATA_W(DATA_W)) s_if ();

  axi_stream_packet_rx #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .aclk         (aclk),
    .areset_n     (areset_n),
    .s_axi_stream (s_if.slave),
    .pkt_valid    (pkt_valid),
    .pkt_len      (pkt_len),
    .pkt_err      (pkt_err),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .pkt_ack      (pkt_ack),
    .drop_cnt     (drop_cnt)
  );

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge aclk);
      #1;
    end
  endtask

  task automatic send_beat(input logic [31:0] d, input logic last, output int waits);
    waits = 0;
    s_if.tdata  = d;
    s_if.tvalid = 1'b1;
    s_if.tlast  = last;
    while (s_if.tready !== 1'b1 && waits < 100) begin
      @(posedge aclk);
      #1;
      waits++;
    end
    checks++;
    if (s_if.tready !== 1'b1) begin
      failures++;
      $display("FAIL tready_timeout got=%b want=1", s_if.tready);
    end
    @(posedge aclk);
    #1;
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
  endtask

  task automatic send_pkt(input logic [31:0] base, input int n, output int max_wait);
    int w;
    int stored;
    max_wait = 0;
    for (int i = 0; i < n; i++) begin
      send_beat(base + 32'(i), (i == n - 1), w);
      if (w > max_wait) max_wait = w;
    end
    stored = (n > DEPTH) ? DEPTH : n;
    exp_len_q.push_back(stored);
    exp_err_q.push_back(n > DEPTH);
    for (int i = 0; i < stored; i++) exp_data_q.push_back(base + 32'(i));
    if (n > DEPTH && exp_drop < 65535) exp_drop++;
  endtask

  task automatic check_pkt(input string name);
    int   n;
    int   len;
    logic err;
    logic [31:0] d;
    n = 0;
    while (pkt_valid !== 1'b1 && n < 100) begin
      @(posedge aclk);
      #1;
      n++;
    end
    checks++;
    if (pkt_valid !== 1'b1) begin
      failures++;
      $display("FAIL %s_pkt_valid got=%b want=1", name, pkt_valid);
    end
    if (exp_len_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s_scoreboard_empty got=0 want=1", name);
      return;
    end
    len = exp_len_q.pop_front();
    err = exp_err_q.pop_front();
    checks++;
    if (pkt_len !== 4'(len)) begin
      failures++;
      $display("FAIL %s_pkt_len got=%0d want=%0d", name, pkt_len, len);
    end
    checks++;
    if (pkt_err !== err) begin
      failures++;
      $display("FAIL %s_pkt_err got=%b want=%b", name, pkt_err, err);
    end
    for (int i = 0; i < len; i++) begin
      rd_addr = 3'(i);
      @(posedge aclk);
      #1;
      d = exp_data_q.pop_front();
      checks++;
      if (rd_data !== d) begin
        failures++;
        $display("FAIL %s_rd_data[%0d] got=%h want=%h", name, i, rd_data, d);
      end
    end
  endtask

  task automatic do_ack();
    pkt_ack = 1'b1;
    @(posedge aclk);
    #1;
    pkt_ack = 1'b0;
  endtask

  task automatic check_drop(input string name);
    checks++;
    if (drop_cnt !== 16'(exp_drop)) begin
      failures++;
      $display("FAIL %s_drop_cnt got=%0d want=%0d", name, drop_cnt, exp_drop);
    end
  endtask

  task automatic test_reset();
    areset_n = 1'b0;
    s_if.tdata = '0;
    s_if.tvalid = 1'b0;
    s_if.tlast = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge aclk);
      #1;
      checks++;
      if (pkt_valid !== 1'b0 || drop_cnt !== 16'd0 || s_if.tready !== 1'b0) begin
        failures++;
        $display("FAIL reset_cycle%0d got=v%b d%0d r%b want=v0 d0 r0", i, pkt_valid, drop_cnt, s_if.tready);
      end
    end
    checks++;
    if (pkt_len !== 4'd0 || pkt_err !== 1'b0 || rd_data !== 32'd0) begin
      failures++;
      $display("FAIL reset_outputs got=len%0d err%b rd%h want=len0 err0 rd0", pkt_len, pkt_err, rd_data);
    end
    areset_n = 1'b1;
    checks++;
    if (s_if.tready !== 1'b0) begin
      failures++;
      $display("FAIL reset_tready_cycle1 got=%b want=0", s_if.tready);
    end
    idle(1);
    checks++;
    if (s_if.tready !== 1'b1 || pkt_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_tready_cycle2 got=r%b v%b want=r1 v0", s_if.tready, pkt_valid);
    end
    check_drop("reset");
  endtask

  task automatic test_single();
    int w;
    send_pkt(32'hA0, 3, w);
    checks++;
    if (pkt_valid !== 1'b1) begin
      failures++;
      $display("FAIL single_valid_latency got=%b want=1", pkt_valid);
    end
    check_pkt("single");
    do_ack();
  endtask

  task automatic test_back_to_back();
    int w1, w2, w3;
    idle(2);
    send_pkt(32'hB0, 2, w1);
    send_pkt(32'hC0, 5, w2);
    checks++;
    if (w1 != 0 || w2 != 0) begin
      failures++;
      $display("FAIL b2b_bubbles got=%0d,%0d want=0,0", w1, w2);
    end
    checks++;
    if (s_if.tready !== 1'b0) begin
      failures++;
      $display("FAIL b2b_tready_full got=%b want=0", s_if.tready);
    end
    check_pkt("b2b_first");
    do_ack();
    checks++;
    if (s_if.tready !== 1'b0 || pkt_valid !== 1'b1 || pkt_len !== 4'd5) begin
      failures++;
      $display("FAIL b2b_after_ack got=r%b v%b len%0d want=r0 v1 len5", s_if.tready, pkt_valid, pkt_len);
    end
    idle(1);
    checks++;
    if (s_if.tready !== 1'b1) begin
      failures++;
      $display("FAIL b2b_tready_return got=%b want=1", s_if.tready);
    end
    send_pkt(32'hD0, 3, w3);
    checks++;
    if (w3 != 0) begin
      failures++;
      $display("FAIL b2b_third_waits got=%0d want=0", w3);
    end
    check_pkt("b2b_second");
    do_ack();
    check_pkt("b2b_third");
    do_ack();
  endtask

  task automatic test_truncate();
    int w;
    idle(2);
    send_pkt(32'h00, 11, w);
    checks++;
    if (w != 0) begin
      failures++;
      $display("FAIL trunc_tready_dropped got=%0d want=0", w);
    end
    check_drop("trunc");
    check_pkt("trunc");
    do_ack();
  endtask

  task automatic test_exact_depth();
    int w;
    idle(2);
    send_pkt(32'h100, 8, w);
    check_drop("exact");
    check_pkt("exact");
    do_ack();
  endtask

  task automatic test_reset_mid_packet();
    int w;
    idle(2);
    for (int i = 0; i < 4; i++) send_beat(32'hE0 + 32'(i), 1'b0, w);
    areset_n = 1'b0;
    idle(2);
    areset_n = 1'b1;
    exp_drop = 0;
    idle(2);
    checks++;
    if (pkt_valid !== 1'b0) begin
      failures++;
      $display("FAIL midrst_valid got=%b want=0", pkt_valid);
    end
    check_drop("midrst");
    do_ack();
    idle(1);
    checks++;
    if (pkt_valid !== 1'b0) begin
      failures++;
      $display("FAIL stray_ack_valid got=%b want=0", pkt_valid);
    end
    send_pkt(32'hF0, 2, w);
    checks++;
    if (pkt_valid !== 1'b1) begin
      failures++;
      $display("FAIL midrst_bank0 got=%b want=1", pkt_valid);
    end
    check_pkt("midrst");
    do_ack();
  endtask

  initial begin
    s_if.tdata  = '0;
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_truncate();
    test_exact_depth();
    test_reset_mid_packet();
    checks++;
    if (exp_len_q.size() != 0 || exp_data_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover got=%0d want=0", exp_len_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
